mmio_gpio_bank: RTL

Parametrised memory-mapped GPIO peripheral for the picorv32 native memory bus. It replaces fixed single-address LED and switch registers with a WIDTH-bit output register, a synchronised input port, and per-bit rising/falling edge capture that drives an interrupt line. The block sits beside the RAM on the CPU bus. Its read data is zero when not acknowledging, so the system can OR it with the other slaves.

---
 rtl/mmio_gpio_bank.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/mmio_gpio_bank.sv
// mmio_gpio_bank
// Memory-mapped GPIO peripheral for the picorv32 native memory bus.
// It provides a WIDTH-bit output register, a synchronised input port and
// per-bit rising/falling edge capture that drives a level interrupt.
// The read data is zero whenever the block is not acknowledging, so it can be
// OR-ed with the other bus slaves.
//
// Ports:
//   sys_clk    : single clock, all logic rising-edge
//   sys_reset  : synchronous active-high reset
//   bus_valid  : CPU mem_valid
//   bus_addr   : CPU byte address
//   bus_wdata  : CPU write data
//   bus_wstrb  : byte strobes; all zero means read
//   bus_ready  : one-cycle acknowledge pulse
//   bus_rdata  : read data, zero whenever bus_ready is low
//   gpio_in    : asynchronous input pins
//   gpio_out   : output register value
//   irq        : OR of (STATUS & IRQ_EN)
//
// Register map (word offsets inside a 32-byte window):
//   0x00 OUT rw, 0x04 IN ro, 0x08 OUT_SET wo, 0x0C OUT_CLR wo,
//   0x10 RISE_EN rw, 0x14 FALL_EN rw, 0x18 IRQ_EN rw, 0x1C STATUS rw1c
module mmio_gpio_bank #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_8000,
  parameter int          WIDTH       = 8,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             sys_clk,
  input  logic             sys_reset,
  input  logic             bus_valid,
  input  logic [31:0]      bus_addr,
  input  logic [31:0]      bus_wdata,
  input  logic [3:0]       bus_wstrb,
  output logic             bus_ready,
  output logic [31:0]      bus_rdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic             irq
);

  localparam logic [2:0] OFF_OUT     = 3'd0;
  localparam logic [2:0] OFF_IN      = 3'd1;
  localparam logic [2:0] OFF_SET     = 3'd2;
  localparam logic [2:0] OFF_CLR     = 3'd3;
  localparam logic [2:0] OFF_RISE_EN = 3'd4;
  localparam logic [2:0] OFF_FALL_EN = 3'd5;
  localparam logic [2:0] OFF_IRQ_EN  = 3'd6;
  localparam logic [2:0] OFF_STATUS  = 3'd7;

  // Expand the four byte strobes into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] strb);
    lane_mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

  logic             sel_s;
  logic             ack_s;
  logic             wr_s;
  logic [2:0]       off_s;
  logic [31:0]      mask32_s;
  logic [WIDTH-1:0] wmask_s;
  logic [WIDTH-1:0] wdata_s;
  logic [WIDTH-1:0] w1c_s;
  logic [WIDTH-1:0] in_s;
  logic [WIDTH-1:0] event_s;
  logic [WIDTH-1:0] rdata_s;
  logic [31:0]      rdata_ext_s;
  logic             unused_s;

  logic             ready_r;
  logic [31:0]      rdata_r;
  logic [WIDTH-1:0] out_r;
  logic [WIDTH-1:0] rise_en_r;
  logic [WIDTH-1:0] fall_en_r;
  logic [WIDTH-1:0] irq_en_r;
  logic [WIDTH-1:0] status_r;
  logic [WIDTH-1:0] prev_r;
  logic [WIDTH-1:0] sync_r [SYNC_STAGES];

  // Data lanes above WIDTH have no storage behind them.
  assign unused_s = ^{bus_wdata, mask32_s};

  // Address decode, handshake qualification and strobe-masked write data.
  always_comb begin
    off_s    = bus_addr[4:2];
    sel_s    = bus_valid && (bus_addr[31:5] == BASE_ADDR[31:5]) &&
               (bus_addr[1:0] == 2'b00);
    // Acknowledge only on the first cycle of a request; ready never repeats.
    ack_s    = sel_s && !ready_r;
    wr_s     = ack_s && (bus_wstrb != 4'b0000);
    mask32_s = lane_mask(bus_wstrb);
    wmask_s  = mask32_s[WIDTH-1:0];
    // A masked lane behaves as zero data, which is what SET/CLR/W1C need.
    wdata_s  = bus_wdata[WIDTH-1:0] & wmask_s;
  end

  // Edge detection on the synchronised inputs.
  always_comb begin
    in_s    = sync_r[SYNC_STAGES-1];
    event_s = (in_s & ~prev_r & rise_en_r) | (~in_s & prev_r & fall_en_r);
  end

  // Clear mask for STATUS, non-zero only on an acknowledged STATUS write.
  always_comb begin
    w1c_s = {WIDTH{1'b0}};
    if (wr_s && (off_s == OFF_STATUS)) begin
      w1c_s = wdata_s;
    end else begin
      w1c_s = {WIDTH{1'b0}};
    end
  end

  // Read multiplexer over pre-edge register state.
  always_comb begin
    rdata_s = {WIDTH{1'b0}};
    case (off_s)
      OFF_OUT:     rdata_s = out_r;
      OFF_IN:      rdata_s = in_s;
      OFF_SET:     rdata_s = {WIDTH{1'b0}};
      OFF_CLR:     rdata_s = {WIDTH{1'b0}};
      OFF_RISE_EN: rdata_s = rise_en_r;
      OFF_FALL_EN: rdata_s = fall_en_r;
      OFF_IRQ_EN:  rdata_s = irq_en_r;
      OFF_STATUS:  rdata_s = status_r;
      default:     rdata_s = {WIDTH{1'b0}};
    endcase
    rdata_ext_s              = 32'h0000_0000;
    rdata_ext_s[WIDTH-1:0]   = rdata_s;
  end

  // Bus acknowledge and registered read data (zero outside the ack cycle).
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      ready_r <= 1'b0;
      rdata_r <= 32'h0000_0000;
    end else begin
      ready_r <= ack_s;
      if (ack_s && (bus_wstrb == 4'b0000)) begin
        rdata_r <= rdata_ext_s;
      end else begin
        rdata_r <= 32'h0000_0000;
      end
    end
  end

  // Input synchroniser chain followed by the previous-value flop.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= {WIDTH{1'b0}};
      end
      prev_r <= {WIDTH{1'b0}};
    end else begin
      sync_r[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      prev_r <= in_s;
    end
  end

  // Control registers and sticky STATUS; a new event beats a same-cycle clear.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      out_r     <= {WIDTH{1'b0}};
      rise_en_r <= {WIDTH{1'b0}};
      fall_en_r <= {WIDTH{1'b0}};
      irq_en_r  <= {WIDTH{1'b0}};
      status_r  <= {WIDTH{1'b0}};
    end else begin
      if (wr_s) begin
        case (off_s)
          OFF_OUT:     out_r     <= (out_r & ~wmask_s) | wdata_s;
          OFF_SET:     out_r     <= out_r | wdata_s;
          OFF_CLR:     out_r     <= out_r & ~wdata_s;
          OFF_RISE_EN: rise_en_r <= (rise_en_r & ~wmask_s) | wdata_s;
          OFF_FALL_EN: fall_en_r <= (fall_en_r & ~wmask_s) | wdata_s;
          OFF_IRQ_EN:  irq_en_r  <= (irq_en_r & ~wmask_s) | wdata_s;
          default: begin
            // IN is read-only and STATUS is handled below.
          end
        endcase
      end
      status_r <= (status_r & ~w1c_s) | event_s;
    end
  end

  assign bus_ready = ready_r;
  assign bus_rdata = rdata_r;
  assign gpio_out  = out_r;
  assign irq       = |(status_r & irq_en_r);

endmodule
